// File: rtl/mips32_prog_loader.sv
// Streams framed program images into instruction memory, then releases the CPU at ENTRY.
// States: IDLE, HEADER, PAYLOAD, CHECK, RELEASE (one-cycle pc_load), DONE, ERROR.
module mips32_prog_loader #(
    parameter int          DEPTH  = 1024,
    parameter int          ADDR_W = 10,
    parameter logic [31:0] ENTRY  = 32'h0
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              pc_load,
    output logic [31:0]       pc_value,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_CHECK,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] DEPTH_17 = 17'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       rem_q, rem_d;
    logic [31:0]       acc_q, acc_d;
    logic [15:0]       words_q, words_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic        hs;
    logic [15:0] hdr_count;
    logic [15:0] hdr_base;
    logic [16:0] hdr_end;

    assign s_ready   = (state_q == S_HEADER) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign hs        = s_valid && s_ready;
    assign hdr_count = s_data[31:16];
    assign hdr_base  = s_data[15:0];
    // 17-bit sum so a frame running past the top of memory cannot wrap and pass
    assign hdr_end   = {1'b0, hdr_base} + {1'b0, hdr_count};

    assign cpu_hold     = !((state_q == S_RELEASE) || (state_q == S_DONE));
    assign pc_load      = (state_q == S_RELEASE);
    assign done         = (state_q == S_DONE);
    assign err          = (state_q == S_ERROR);
    assign pc_value     = ENTRY;
    assign err_code     = err_code_q;
    assign words_loaded = words_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        words_d     = words_q;
        err_code_d  = err_code_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_HEADER;
            end
            S_HEADER: begin
                if (hs) begin
                    if (hdr_count == 16'd0) begin
                        state_d = S_RELEASE;
                    end else if (hdr_end > DEPTH_17) begin
                        err_code_d = 2'd1;
                        state_d    = S_ERROR;
                    end else begin
                        ptr_d   = hdr_base[ADDR_W-1:0];
                        rem_d   = hdr_count;
                        acc_d   = 32'h0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (hs) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = s_data;
                    acc_d       = acc_q ^ s_data;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    rem_d       = rem_q - 16'd1;
                    words_d     = words_q + 16'd1;
                    if (rem_q == 16'd1) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hs) begin
                    if (s_data == acc_q) begin
                        state_d = S_HEADER;
                    end else begin
                        err_code_d = 2'd2;
                        state_d    = S_ERROR;
                    end
                end
            end
            S_RELEASE: state_d = S_DONE;
            S_DONE:    state_d = S_DONE;
            S_ERROR: begin
                if (start) begin
                    err_code_d = 2'd0;
                    words_d    = 16'd0;
                    state_d    = S_HEADER;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rem_q       <= 16'd0;
            acc_q       <= 32'h0;
            words_q     <= 16'd0;
            err_code_q  <= 2'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            words_q     <= words_d;
            err_code_q  <= err_code_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Scoreboard bench for mips32_prog_loader: expected writes queued at handshake, checked at mem_we.
module tb_mips32_prog_loader;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk1;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        pc_load;
    logic [31:0] pc_value;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    int tests_run    = 0;
    int tests_failed = 0;
    int write_cnt    = 0;
    int pc_cnt       = 0;
    wr_t exp_q[$];

    logic [31:0] prog [8] = '{32'h28010078, 32'h0c211800, 32'h28230004, 32'h2c240004,
                              32'h00832800, 32'h2c050078, 32'h0ca62000, 32'hfc000000};

    mips32_prog_loader #(.DEPTH(1024), .ADDR_W(10), .ENTRY(32'h0)) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .pc_load(pc_load), .pc_value(pc_value), .done(done),
        .err(err), .err_code(err_code), .words_loaded(words_loaded)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // write and pc_load monitor, sampled mid-cycle
    always @(negedge clk1) begin
        if (mem_we === 1'b1) begin
            wr_t e;
            write_cnt++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    tests_failed++;
                    $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
        if (pc_load === 1'b1) pc_cnt++;
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'h0;
        @(negedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
        write_cnt = 0;
        pc_cnt    = 0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input bit is_pl, input logic [9:0] a, input int gap);
        int n;
        wr_t e;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk1);
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk1);
            n++;
        end
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL send_timeout: s_ready=%b for word %h, expected 1", s_ready, d);
        end else if (is_pl) begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
        @(negedge clk1);
        s_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = 32'h0;
        @(negedge clk1);
        @(negedge clk1);
        if (s_ready !== 1'b0 || cpu_hold !== 1'b1 || mem_we !== 1'b0 || pc_load !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got ready=%b hold=%b we=%b pcl=%b done=%b err=%b, expected 0 1 0 0 0 0",
                     s_ready, cpu_hold, mem_we, pc_load, done, err);
        end
        tests_run++;
        if (err_code !== 2'd0 || words_loaded !== 16'd0 || mem_addr !== 10'd0 ||
            mem_wdata !== 32'h0 || pc_value !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got code=%0d words=%0d addr=%0d wdata=%h pc=%h, expected all 0",
                     err_code, words_loaded, mem_addr, mem_wdata, pc_value);
        end
        tests_run++;
        // IDLE must not accept words before start
        s_valid = 1'b1;
        rst_n = 1'b1;
        @(negedge clk1);
        check("idle_not_ready", {31'h0, s_ready}, 32'h0);
        s_valid = 1'b0;
    endtask

    task automatic test_full_load(input int gap);
        logic [31:0] cs;
        do_reset();
        pulse_start();
        send_word(32'h00080000, 1'b0, 10'd0, gap);
        cs = 32'h0;
        for (int i = 0; i < 8; i++) begin
            send_word(prog[i], 1'b1, 10'(i), gap);
            cs ^= prog[i];
        end
        send_word(cs, 1'b0, 10'd0, gap);
        send_word(32'h00010078, 1'b0, 10'd0, gap);
        send_word(32'd85, 1'b1, 10'd120, gap);
        send_word(32'd85, 1'b0, 10'd0, gap);
        send_word(32'h00000000, 1'b0, 10'd0, gap);
        check("release_pc_load", {31'h0, pc_load}, 32'h1);
        check("release_hold", {31'h0, cpu_hold}, 32'h0);
        check("release_pc_value", pc_value, 32'h0);
        @(negedge clk1);
        check("done_flag", {31'h0, done}, 32'h1);
        check("done_hold", {31'h0, cpu_hold}, 32'h0);
        check("done_words", {16'h0, words_loaded}, 32'd9);
        pulse_start();
        @(negedge clk1);
        check("done_ignores_start", {30'h0, done, s_ready}, 32'h2);
        check("full_write_cnt", write_cnt, 32'd9);
        check("full_pc_cnt", pc_cnt, 32'd1);
        check("full_queue_empty", exp_q.size(), 32'd0);
    endtask

    task automatic test_checksum_fail();
        do_reset();
        pulse_start();
        send_word(32'h00010005, 1'b0, 10'd0, 0);
        send_word(32'h12345678, 1'b1, 10'd5, 0);
        send_word(32'h12345679, 1'b0, 10'd0, 0);
        check("cs_err", {31'h0, err}, 32'h1);
        check("cs_code", {30'h0, err_code}, 32'd2);
        check("cs_hold", {31'h0, cpu_hold}, 32'h1);
        check("cs_ready", {31'h0, s_ready}, 32'h0);
        @(negedge clk1);
        @(negedge clk1);
        check("cs_write_cnt", write_cnt, 32'd1);
        check("cs_pc_cnt", pc_cnt, 32'd0);
        check("cs_words", {16'h0, words_loaded}, 32'd1);
    endtask

    task automatic test_error_recovery();
        pulse_start();
        check("rec_err_clear", {29'h0, err, err_code}, 32'h0);
        check("rec_words_clear", {16'h0, words_loaded}, 32'd0);
        send_word(32'h00010010, 1'b0, 10'd0, 0);
        send_word(32'hcafef00d, 1'b1, 10'd16, 0);
        send_word(32'hcafef00d, 1'b0, 10'd0, 0);
        send_word(32'h00000000, 1'b0, 10'd0, 0);
        @(negedge clk1);
        check("rec_done", {30'h0, done, err}, 32'h2);
        check("rec_words", {16'h0, words_loaded}, 32'd1);
        check("rec_write_cnt", write_cnt, 32'd2);
    endtask

    task automatic test_range();
        do_reset();
        pulse_start();
        send_word(32'h000403FE, 1'b0, 10'd0, 0);
        check("range_err", {31'h0, err}, 32'h1);
        check("range_code", {30'h0, err_code}, 32'd1);
        @(negedge clk1);
        check("range_ready", {31'h0, s_ready}, 32'h0);
        check("range_writes", write_cnt, 32'd0);
        // a frame ending exactly at the top of memory is legal
        do_reset();
        pulse_start();
        send_word(32'h000203FE, 1'b0, 10'd0, 0);
        send_word(32'h11112222, 1'b1, 10'd1022, 0);
        send_word(32'h33334444, 1'b1, 10'd1023, 0);
        send_word(32'h11112222 ^ 32'h33334444, 1'b0, 10'd0, 0);
        send_word(32'h00000000, 1'b0, 10'd0, 0);
        @(negedge clk1);
        check("edge_done", {30'h0, done, err}, 32'h2);
        check("edge_writes", write_cnt, 32'd2);
    endtask

    task automatic test_reset_mid_payload();
        do_reset();
        pulse_start();
        send_word(32'h00080000, 1'b0, 10'd0, 0);
        for (int i = 0; i < 3; i++) send_word(prog[i], 1'b1, 10'(i), 0);
        rst_n = 1'b0;
        s_valid = 1'b1;
        s_data = prog[3];
        @(negedge clk1);
        check("mid_hold", {31'h0, cpu_hold}, 32'h1);
        check("mid_ready", {31'h0, s_ready}, 32'h0);
        check("mid_words", {16'h0, words_loaded}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk1);
        @(negedge clk1);
        s_valid = 1'b0;
        check("mid_write_cnt", write_cnt, 32'd3);
        check("mid_idle_ready", {31'h0, s_ready}, 32'h0);
        check("mid_queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'h0;
        test_reset();
        test_full_load(0);
        test_full_load(1);
        test_checksum_fail();
        test_error_recovery();
        test_range();
        test_reset_mid_payload();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
